// File: rtl/arb_pkg.sv
// Types shared by the weighted-arbitration tracker and its per-requester counters.
package arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/arb_weight_counter.sv
// Per-requester transaction counter: counts completed grants up to the effective
// weight and raises a sticky "weight used" flag until the round is cleared.
module arb_weight_counter #(
    parameter int P_WEIGHT_W = 4
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  inc,
    input  logic                  round_clear,
    input  logic [P_WEIGHT_W-1:0] weight,
    output logic                  completed_next,
    output logic                  completed
);

    logic [P_WEIGHT_W-1:0] cnt_reg;
    logic                  completed_reg;
    logic [P_WEIGHT_W-1:0] eff_weight;
    logic [P_WEIGHT_W:0]   cnt_plus_one;
    logic                  hit;

    // One extra bit on the compare so an all-ones counter cannot wrap past the weight.
    always_comb begin
        eff_weight     = (weight == '0) ? P_WEIGHT_W'(1) : weight;
        cnt_plus_one   = {1'b0, cnt_reg} + (P_WEIGHT_W + 1)'(1);
        hit            = inc && (cnt_plus_one >= {1'b0, eff_weight});
        completed_next = completed_reg | hit;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg       <= '0;
            completed_reg <= 1'b0;
        end else if (round_clear) begin
            cnt_reg       <= '0;
            completed_reg <= 1'b0;
        end else begin
            completed_reg <= completed_next;
            if (hit) begin
                cnt_reg <= '0;
            end else if (inc) begin
                cnt_reg <= cnt_plus_one[P_WEIGHT_W-1:0];
            end
        end
    end

    assign completed = completed_reg;

endmodule

// File: rtl/arb_weight_tracker.sv
// Holds the priority granter's choice until downstream finishes it, and tracks
// how much of each requester's weight has been spent in the current round.
module arb_weight_tracker
    import arb_pkg::*;
#(
    parameter int P_REQUESTER_NUM = 3,
    parameter int P_WEIGHT_W      = 4
) (
    input  logic                                ACLK,
    input  logic                                ARESET,
    input  logic [P_REQUESTER_NUM-1:0]          request,
    input  logic [P_REQUESTER_NUM-1:0]          prior_grant,
    input  logic [P_REQUESTER_NUM*P_WEIGHT_W-1:0] request_weight,
    input  logic                                grant_ready,
    output logic                                grant_valid,
    output logic [P_REQUESTER_NUM-1:0]          grant,
    output logic [P_REQUESTER_NUM-1:0]          request_weight_completed
);

    arb_state_e                 state_reg, state_next;
    logic [P_REQUESTER_NUM-1:0] grant_reg, grant_next;
    logic                       valid_reg, valid_next;
    logic                       complete_txn;
    logic [P_REQUESTER_NUM-1:0] inc_vec;
    logic [P_REQUESTER_NUM-1:0] next_completed;
    logic [P_REQUESTER_NUM-1:0] completed_vec;
    logic                       round_clear;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_reg <= ST_IDLE;
            grant_reg <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            valid_reg <= valid_next;
        end
    end

    // A held grant is released only by grant_ready; a dropped request does not abort it.
    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        valid_next   = valid_reg;
        complete_txn = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                grant_next = '0;
                valid_next = 1'b0;
                if (|request) begin
                    grant_next = prior_grant;
                    valid_next = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (grant_ready) begin
                    complete_txn = 1'b1;
                    grant_next   = '0;
                    valid_next   = 1'b0;
                    state_next   = ST_IDLE;
                end
            end
            default: begin
                grant_next = '0;
                valid_next = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    assign inc_vec = complete_txn ? grant_reg : '0;

    generate
        for (genvar gi = 0; gi < P_REQUESTER_NUM; gi++) begin : g_cnt
            arb_weight_counter #(
                .P_WEIGHT_W (P_WEIGHT_W)
            ) u_cnt (
                .clk            (ACLK),
                .srst           (ARESET),
                .inc            (inc_vec[gi]),
                .round_clear    (round_clear),
                .weight         (request_weight[gi*P_WEIGHT_W +: P_WEIGHT_W]),
                .completed_next (next_completed[gi]),
                .completed      (completed_vec[gi])
            );
        end
    endgenerate

    // Round ends once every active requester has spent its weight.
    assign round_clear = ((request & ~next_completed) == '0) && (next_completed != '0);

    assign grant_valid              = valid_reg;
    assign grant                    = grant_reg;
    assign request_weight_completed = completed_vec;

    a_prior_grant_onehot: assert property (
        @(posedge ACLK) disable iff (ARESET)
        (state_reg == ST_IDLE && |request) |-> $onehot(prior_grant)
    );

endmodule

// File: tb/tb_arb_weight_tracker.sv
// Scoreboard bench for arb_weight_tracker: a behavioural model predicts each
// cycle's outputs, and grant order is checked against fixed sequences.
module tb_arb_weight_tracker;

    localparam int N = 3;
    localparam int W = 4;

    logic           ACLK = 1'b0;
    logic           ARESET;
    logic [N-1:0]   request;
    logic [N-1:0]   prior_grant;
    logic [N*W-1:0] request_weight;
    logic           grant_ready;
    logic           grant_valid;
    logic [N-1:0]   grant;
    logic [N-1:0]   request_weight_completed;

    arb_weight_tracker #(
        .P_REQUESTER_NUM (N),
        .P_WEIGHT_W      (W)
    ) dut (
        .ACLK                     (ACLK),
        .ARESET                   (ARESET),
        .request                  (request),
        .prior_grant              (prior_grant),
        .request_weight           (request_weight),
        .grant_ready              (grant_ready),
        .grant_valid              (grant_valid),
        .grant                    (grant),
        .request_weight_completed (request_weight_completed)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic         v;
        logic [N-1:0] g;
        logic [N-1:0] c;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    int   total = 0;
    int   bad   = 0;

    int           w[N];
    int           m_cnt[N];
    logic         m_hold;
    logic [N-1:0] m_grant;
    logic [N-1:0] m_comp;
    logic         prev_valid;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference priority granter: lowest-index requester that still has weight left.
    function automatic logic [N-1:0] pick(input logic [N-1:0] req, input logic [N-1:0] comp);
        logic [N-1:0] avail;
        avail = req & ~comp;
        if (avail == '0) avail = req;
        pick = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (avail[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
    endfunction

    function automatic int idx(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_hold  = 1'b0;
        m_grant = '0;
        m_comp  = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    task automatic cycle();
        logic [N-1:0] pg;
        logic [N-1:0] nc;
        int           eff;
        exp_t         e;
        exp_t         got;
        for (int i = 0; i < N; i++) request_weight[i*W +: W] = W'(w[i]);
        pg          = pick(request, m_comp);
        prior_grant = pg;
        if (ARESET) begin
            model_reset();
        end else begin
            nc = m_comp;
            if (!m_hold) begin
                if (|request) begin
                    m_grant = pg;
                    m_hold  = 1'b1;
                end
            end else if (grant_ready) begin
                for (int i = 0; i < N; i++) begin
                    if (m_grant[i]) begin
                        eff = (w[i] == 0) ? 1 : w[i];
                        if (m_cnt[i] + 1 >= eff) begin
                            m_cnt[i] = 0;
                            nc[i]    = 1'b1;
                        end else begin
                            m_cnt[i] = m_cnt[i] + 1;
                        end
                    end
                end
                m_hold  = 1'b0;
                m_grant = '0;
            end
            if (((request & ~nc) == '0) && (nc != '0)) begin
                nc = '0;
                for (int i = 0; i < N; i++) m_cnt[i] = 0;
            end
            m_comp = nc;
        end
        e.v = m_hold;
        e.g = m_grant;
        e.c = m_comp;
        exp_q.push_back(e);
        @(posedge ACLK);
        #1;
        got = exp_q.pop_front();
        check_val("grant_valid", 32'(grant_valid), 32'(got.v));
        check_val("grant", 32'(grant), 32'(got.g));
        check_val("completed", 32'(request_weight_completed), 32'(got.c));
        if (grant_valid && !prev_valid) grant_log.push_back(idx(grant));
        prev_valid = grant_valid;
    endtask

    task automatic check_order(input string tag, input int exp_seq[12], input int n);
        if (grant_log.size() < n) begin
            check_val({tag, "_count"}, 32'(grant_log.size()), 32'(n));
        end else begin
            for (int k = 0; k < n; k++) check_val(tag, 32'(grant_log[k]), 32'(exp_seq[k]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int order_w123[12] = '{0, 1, 1, 2, 2, 2, 0, 1, 1, 2, 2, 2};
        int order_r0[12]   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        int order_r1[12]   = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        int budget;

        prev_valid     = 1'b0;
        ARESET         = 1'b1;
        request        = '0;
        prior_grant    = '0;
        grant_ready    = 1'b0;
        request_weight = '0;
        w              = '{1, 2, 3};
        model_reset();
        repeat (3) cycle();
        ARESET = 1'b0;

        // Weights 1,2,3 with everyone requesting: two full rounds
        request     = 3'b111;
        grant_ready = 1'b1;
        grant_log.delete();
        repeat (24) cycle();
        check_order("order_w123", order_w123, 12);

        // Single requester, weight 2: round clears silently, grants keep flowing
        request = 3'b000;
        cycle();
        w[0]    = 2;
        request = 3'b001;
        grant_log.delete();
        repeat (8) cycle();
        check_order("order_r0", order_r0, 4);

        // Weight 0 treated as 1
        request = 3'b000;
        cycle();
        w[1]    = 0;
        request = 3'b010;
        grant_log.delete();
        repeat (6) cycle();
        check_order("order_r1", order_r1, 3);

        // Long hold with request dropped, then release
        request = 3'b000;
        cycle();
        w[0]        = 2;
        request     = 3'b011;
        grant_ready = 1'b0;
        cycle();
        request = 3'b000;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check_val("hold_grant", 32'(grant), 32'(3'b001));
        end
        grant_ready = 1'b1;
        cycle();
        check_val("release_valid", 32'(grant_valid), 32'(0));
        request = 3'b011;
        repeat (2) cycle();
        check_val("cnt_counted_hold", 32'(request_weight_completed), 32'(3'b001));

        // Reset mid-hold with cnt[2]=2
        ARESET = 1'b1;
        cycle();
        ARESET      = 1'b0;
        w           = '{1, 2, 3};
        request     = 3'b111;
        grant_ready = 1'b1;
        budget      = 0;
        do begin
            cycle();
            budget++;
        end while (!(m_hold && m_cnt[2] == 2) && budget < 40);
        check_val("reach_cnt2_hold", 32'(budget < 40), 32'(1));
        ARESET = 1'b1;
        cycle();
        check_val("rst_valid", 32'(grant_valid), 32'(0));
        check_val("rst_grant", 32'(grant), 32'(0));
        check_val("rst_completed", 32'(request_weight_completed), 32'(0));
        ARESET = 1'b0;
        grant_log.delete();
        repeat (12) cycle();
        check_order("order_after_rst", order_w123, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
